// File: rtl/serial_mem_responder_pkg.sv
// Shared opcodes, start-beat value, state encoding and bus defaults.
// Also imported by the CPU-side prefetcher.
package serial_mem_responder_pkg;

  localparam int DEF_IO_BITS        = 2;
  localparam int DEF_PAYLOAD_CYCLES = 8;

  localparam int HDR_READ16  = 0;
  localparam int HDR_WRITE16 = 1;
  localparam int START_BEAT  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_ADDR,
    S_WDATA,
    S_WAIT,
    S_RSTART,
    S_RDATA
  } state_t;

endpackage

// File: rtl/serial_mem_responder_shift_reg.sv
// Chunk shift register: parallel load, or shift right with the new
// chunk entering at the MSB end (LSB chunk ends up lowest).
module serial_shift_reg
  import serial_mem_responder_pkg::*;
#(
  parameter int IO_BITS = DEF_IO_BITS,
  parameter int BITS    = 16
) (
  input  logic               clk,
  input  logic               i_load,
  input  logic [BITS-1:0]    i_load_val,
  input  logic               i_shift,
  input  logic [IO_BITS-1:0] i_din,
  output logic [BITS-1:0]    o_q
);

  logic [BITS-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= {i_din, r_q[BITS-1:IO_BITS]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_mem_responder.sv
// Serial-bus word memory responder: READ16 always, WRITE16 only when
// SERIAL_MEM_RESPONDER_WRITE_EN is defined.
module serial_mem_responder
  import serial_mem_responder_pkg::*;
#(
  parameter int IO_BITS        = DEF_IO_BITS,
  parameter int PAYLOAD_CYCLES = DEF_PAYLOAD_CYCLES,
  parameter int MEM_ADDR_BITS  = 8,
  parameter int RESP_DELAY     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IO_BITS-1:0]       rx_pins,
  output logic [IO_BITS-1:0]       tx_pins,
  output logic                     busy,
  output logic                     overrun,
  input  logic [MEM_ADDR_BITS-1:0] dbg_addr,
  output logic [15:0]              dbg_data
);

  localparam logic [2:0] LAST_BEAT = 3'(PAYLOAD_CYCLES - 1);
  localparam logic [3:0] LAST_WAIT =
    4'((RESP_DELAY == 0) ? 0 : RESP_DELAY - 1);

  state_t                   r_state;
  logic [2:0]               r_cnt;
  logic [3:0]               r_wait;
  logic [IO_BITS-1:0]       r_tx;
  logic                     r_overrun;
  logic [MEM_ADDR_BITS-1:0] r_index;
  logic [15:0]              r_mem [2**MEM_ADDR_BITS];

  logic [15:0] w_des;
  logic [15:0] w_ser;
  logic [15:0] w_shift_next;
  logic [15:0] w_rdata;
  logic        w_des_shift;
  logic        w_hdr_ok;
  logic        w_to_wdata;
  logic        w_unused;

  assign w_shift_next = {rx_pins, w_des[15:IO_BITS]};
  assign w_rdata      = r_mem[r_index];

`ifdef SERIAL_MEM_RESPONDER_WRITE_EN
  logic r_wr_op;
  logic w_we;

  assign w_hdr_ok    = (rx_pins == IO_BITS'(HDR_READ16)) ||
                       (rx_pins == IO_BITS'(HDR_WRITE16));
  assign w_to_wdata  = r_wr_op;
  assign w_des_shift = (r_state == S_ADDR) || (r_state == S_WDATA);
  // Gated by reset so an abandoned write never lands.
  assign w_we = !reset && (r_state == S_WDATA) && (r_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (r_state == S_HEADER) begin
      r_wr_op <= (rx_pins == IO_BITS'(HDR_WRITE16));
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_index] <= w_shift_next;
    end
  end
`else
  assign w_hdr_ok    = (rx_pins == IO_BITS'(HDR_READ16));
  assign w_to_wdata  = 1'b0;
  assign w_des_shift = (r_state == S_ADDR);
`endif

  serial_shift_reg #(
    .IO_BITS(IO_BITS),
    .BITS   (16)
  ) u_des (
    .clk       (clk),
    .i_load    (1'b0),
    .i_load_val(16'h0000),
    .i_shift   (w_des_shift),
    .i_din     (rx_pins),
    .o_q       (w_des)
  );

  serial_shift_reg #(
    .IO_BITS(IO_BITS),
    .BITS   (16)
  ) u_ser (
    .clk       (clk),
    .i_load    (r_state == S_RSTART),
    .i_load_val(w_rdata),
    .i_shift   (r_state == S_RDATA),
    .i_din     ('0),
    .o_q       (w_ser)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wait    <= '0;
      r_tx      <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_tx <= '0;
      if ((r_state == S_WAIT || r_state == S_RSTART ||
           r_state == S_RDATA) && rx_pins[0]) begin
        r_overrun <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (rx_pins[0]) r_state <= S_HEADER;
        end
        S_HEADER: begin
          r_cnt   <= '0;
          r_state <= w_hdr_ok ? S_ADDR : S_IDLE;
        end
        S_ADDR: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == LAST_BEAT) begin
            r_cnt   <= '0;
            r_index <= w_shift_next[MEM_ADDR_BITS:1];
            if (w_to_wdata) begin
              r_state <= S_WDATA;
            end else if (RESP_DELAY == 0) begin
              r_state <= S_RSTART;
              r_tx    <= IO_BITS'(START_BEAT);
            end else begin
              r_state <= S_WAIT;
              r_wait  <= '0;
            end
          end
        end
`ifdef SERIAL_MEM_RESPONDER_WRITE_EN
        S_WDATA: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == LAST_BEAT) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
`endif
        S_WAIT: begin
          r_wait <= r_wait + 4'd1;
          if (r_wait == LAST_WAIT) begin
            r_state <= S_RSTART;
            r_tx    <= IO_BITS'(START_BEAT);
          end
        end
        S_RSTART: begin
          r_state <= S_RDATA;
          r_cnt   <= '0;
          r_tx    <= w_rdata[IO_BITS-1:0];
        end
        S_RDATA: begin
          r_cnt <= r_cnt + 3'd1;
          // Serializer still holds the beat on the wire; next is one chunk up.
          if (r_cnt == LAST_BEAT) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tx <= w_ser[2*IO_BITS-1:IO_BITS];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_pins  = r_tx;
  assign busy     = (r_state != S_IDLE);
  assign overrun  = r_overrun;
  assign dbg_data = r_mem[dbg_addr];

  assign w_unused = ^{w_des[IO_BITS-1:0], w_ser[IO_BITS-1:0],
                      w_ser[15:2*IO_BITS], w_shift_next[0],
                      w_shift_next[15:MEM_ADDR_BITS+1]};

endmodule

// File: tb/tb_serial_mem_responder.sv
// Directed bench for serial_mem_responder (default parameters);
// follows SERIAL_MEM_RESPONDER_WRITE_EN for the write/read-only cases.
module tb_serial_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rx_pins;
  logic [1:0]  tx_pins;
  logic        busy;
  logic        overrun;
  logic [7:0]  dbg_addr;
  logic [15:0] dbg_data;

  int          total = 0;
  int          bad   = 0;
  logic [1:0]  txacc;

  serial_mem_responder dut (
    .clk     (clk),
    .reset   (reset),
    .rx_pins (rx_pins),
    .tx_pins (tx_pins),
    .busy    (busy),
    .overrun (overrun),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [1:0] v);
    rx_pins = v;
    tick();
    txacc = txacc | tx_pins;
  endtask

  task automatic send_cmd(input logic [1:0] hdr, input logic [15:0] addr,
                          input logic [15:0] data, input logic with_data);
    beat(2'd1);
    beat(hdr);
    for (int i = 0; i < 8; i++) beat(addr[2*i +: 2]);
    if (with_data) begin
      for (int i = 0; i < 8; i++) beat(data[2*i +: 2]);
    end
    rx_pins = 2'd0;
  endtask

  // Returns in the first cycle after RDATA; inj = data beat carrying a start.
  task automatic do_read(input logic [15:0] addr, input logic [15:0] exp,
                         input int inj, input string tag);
    logic [15:0] got;
    got = 16'h0;
    send_cmd(2'd0, addr, 16'h0, 1'b0);
    chk({tag, "_wait_tx"}, 16'(tx_pins), 16'd0);
    tick();
    chk({tag, "_start"}, 16'(tx_pins), 16'd1);
    tick();
    for (int k = 0; k < 8; k++) begin
      rx_pins = (k == inj) ? 2'd1 : 2'd0;
      got[2*k +: 2] = tx_pins;
      tick();
    end
    rx_pins = 2'd0;
    chk({tag, "_data"}, got, exp);
    chk({tag, "_busy_end"}, 16'(busy), 16'd0);
    chk({tag, "_tx_end"}, 16'(tx_pins), 16'd0);
  endtask

  initial begin
    logic [1:0] seq [9];
    logic [2:0] acc;
    seq = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    reset    = 1'b1;
    rx_pins  = 2'd0;
    dbg_addr = 8'h00;
    txacc    = 2'd0;
`ifndef SERIAL_MEM_RESPONDER_WRITE_EN
    dut.r_mem[8'h12] = 16'hBEEF;
    dut.r_mem[8'h20] = 16'hCAFE;
`endif
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_tx", 16'(tx_pins), 16'd0);
    chk("rst_overrun", 16'(overrun), 16'd0);

`ifdef SERIAL_MEM_RESPONDER_WRITE_EN
    send_cmd(2'd1, 16'h0024, 16'hBEEF, 1'b1);
    dbg_addr = 8'h12;
    #1;
    chk("wr_beef", dbg_data, 16'hBEEF);
    txacc = 2'd0;
    send_cmd(2'd1, 16'h0040, 16'h1234, 1'b1);
    dbg_addr = 8'h20;
    #1;
    chk("wr_dbg", dbg_data, 16'h1234);
    chk("wr_no_tx", 16'(txacc), 16'd0);
    chk("wr_busy", 16'(busy), 16'd0);
    do_read(16'h0041, 16'h1234, -1, "rd_wr");
`else
    dbg_addr = 8'h20;
    #1;
    chk("ro_pre", dbg_data, 16'hCAFE);
    beat(2'd1);
    beat(2'd1);
    rx_pins = 2'd0;
    chk("ro_wr_idle", 16'(busy), 16'd0);
    tick();
    chk("ro_wr_tx", 16'(tx_pins), 16'd0);
    chk("ro_mem", dbg_data, 16'hCAFE);
`endif

    do_read(16'h0024, 16'hBEEF, -1, "rd");
    do_read(16'h0224, 16'hBEEF, -1, "alias");

    beat(2'd1);
    beat(2'd2);
    rx_pins = 2'd0;
    chk("rsv_idle", 16'(busy), 16'd0);
    chk("rsv_tx", 16'(tx_pins), 16'd0);
    tick();
    chk("rsv_tx2", 16'(tx_pins), 16'd0);
    chk("pre_overrun", 16'(overrun), 16'd0);

    do_read(16'h0024, 16'hBEEF, 2, "ovr");
    chk("ovr_flag", 16'(overrun), 16'd1);
    acc = 3'd0;
    for (int i = 0; i < 9; i++) begin
      rx_pins = seq[i];
      acc = acc | {busy, tx_pins};
      tick();
    end
    rx_pins = 2'd0;
    acc = acc | {busy, tx_pins};
    chk("ovr_no_frame", 16'(acc), 16'd0);

    do_read(16'h0024, 16'hBEEF, 7, "last_beat");
    do_read(16'h0224, 16'hBEEF, -1, "back2back");

    send_cmd(2'd0, 16'h0024, 16'h0, 1'b0);
    tick();
    tick();
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_tx", 16'(tx_pins), 16'd0);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_ovr", 16'(overrun), 16'd0);
    do_read(16'h0024, 16'hBEEF, -1, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
